// File: rtl/config_pkg.sv
// Minimal core configuration package: only the fields this block consumes.
package config_pkg;

    typedef struct packed {
        int unsigned XLEN;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '{XLEN: 64};

endpackage

// File: rtl/hpm_overflow_ctrl.sv
// HPM counter overflow control: per-counter privilege inhibit bits, sticky overflow
// flags, scountovf view and the local counter-overflow interrupt (LCOFI).
module hpm_overflow_ctrl #(
    parameter config_pkg::cva6_cfg_t CVA6Cfg     = config_pkg::cva6_cfg_empty,
    parameter int unsigned           NumCounters = 6
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                debug_mode_i,
    input  logic [1:0]                          priv_lvl_i,
    input  logic [NumCounters-1:0]              cnt_inc_i,
    input  logic [NumCounters-1:0][63:0]        cnt_val_i,
    input  logic [NumCounters-1:0]              cnt_we_i,
    input  logic [11:0]                         addr_i,
    input  logic                                we_i,
    input  logic [CVA6Cfg.XLEN-1:0]             data_i,
    output logic [CVA6Cfg.XLEN-1:0]             data_o,
    input  logic                                lcofi_clr_i,
    output logic [NumCounters-1:0]              inc_en_o,
    output logic [NumCounters-1:0]              of_o,
    output logic                                lcofi_o
);

    localparam int unsigned XLEN = CVA6Cfg.XLEN;

    // RV32 keeps the config bits in the high half (mhpmeventh); the low half maps nothing.
    localparam logic [11:0] CfgBase    = (XLEN == 64) ? 12'h323 : 12'h723;
    localparam logic [11:0] ScountovfA = 12'hDA0;

    localparam logic [1:0] PrivU = 2'b00;
    localparam logic [1:0] PrivS = 2'b01;
    localparam logic [1:0] PrivM = 2'b11;

    logic [NumCounters-1:0] r_of;
    logic [NumCounters-1:0] r_minh;
    logic [NumCounters-1:0] r_sinh;
    logic [NumCounters-1:0] r_uinh;
    logic                   r_lcofi;

    logic [NumCounters-1:0] w_of_nxt;
    logic [NumCounters-1:0] w_minh_nxt;
    logic [NumCounters-1:0] w_sinh_nxt;
    logic [NumCounters-1:0] w_uinh_nxt;
    logic                   w_lcofi_nxt;

    logic [NumCounters-1:0] w_cfg_sel;
    logic [NumCounters-1:0] w_cfg_wr;
    logic [NumCounters-1:0] w_ovf_evt;
    logic [3:0]             w_wr_field;
    logic                   w_unused_data;

    assign w_wr_field    = data_i[XLEN-1 -: 4];
    assign w_unused_data = ^data_i[XLEN-5:0];

    always_comb begin
        w_cfg_sel = '0;
        w_ovf_evt = '0;
        inc_en_o  = '0;
        for (int i = 0; i < NumCounters; i++) begin
            w_cfg_sel[i] = (addr_i == CfgBase + 12'(i));
            w_ovf_evt[i] = cnt_inc_i[i] & (&cnt_val_i[i]) & ~cnt_we_i[i] & ~debug_mode_i;
            inc_en_o[i]  = ~((r_minh[i] & (priv_lvl_i == PrivM)) |
                             (r_sinh[i] & (priv_lvl_i == PrivS)) |
                             (r_uinh[i] & (priv_lvl_i == PrivU)) |
                             debug_mode_i);
        end
        w_cfg_wr = w_cfg_sel & {NumCounters{we_i}};
    end

    // Hardware overflow beats a same-cycle software write of the OF bit.
    always_comb begin
        w_of_nxt   = r_of;
        w_minh_nxt = r_minh;
        w_sinh_nxt = r_sinh;
        w_uinh_nxt = r_uinh;
        for (int i = 0; i < NumCounters; i++) begin
            if (w_cfg_wr[i]) begin
                w_of_nxt[i]   = w_wr_field[3];
                w_minh_nxt[i] = w_wr_field[2];
                w_sinh_nxt[i] = w_wr_field[1];
                w_uinh_nxt[i] = w_wr_field[0];
            end
            if (w_ovf_evt[i]) begin
                w_of_nxt[i] = 1'b1;
            end
        end
        // Only a fresh 0->1 hardware transition raises the interrupt.
        w_lcofi_nxt = (|(w_ovf_evt & ~r_of)) | (r_lcofi & ~lcofi_clr_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_of    <= '0;
            r_minh  <= '0;
            r_sinh  <= '0;
            r_uinh  <= '0;
            r_lcofi <= 1'b0;
        end else begin
            r_of    <= w_of_nxt;
            r_minh  <= w_minh_nxt;
            r_sinh  <= w_sinh_nxt;
            r_uinh  <= w_uinh_nxt;
            r_lcofi <= w_lcofi_nxt;
        end
    end

    always_comb begin
        data_o = '0;
        if (addr_i == ScountovfA) begin
            for (int i = 0; i < NumCounters; i++) begin
                data_o[i+3] = r_of[i];
            end
        end
        for (int i = 0; i < NumCounters; i++) begin
            if (w_cfg_sel[i]) begin
                data_o[XLEN-1 -: 4] = {r_of[i], r_minh[i], r_sinh[i], r_uinh[i]};
            end
        end
    end

    assign of_o    = r_of;
    assign lcofi_o = r_lcofi;

endmodule

// File: tb/tb_hpm_overflow_ctrl.sv
// Directed self-checking bench for hpm_overflow_ctrl, covering both RV64 and RV32 builds.
module tb_hpm_overflow_ctrl;

    localparam config_pkg::cva6_cfg_t Cfg64 = '{XLEN: 64};
    localparam config_pkg::cva6_cfg_t Cfg32 = '{XLEN: 32};

    logic             clk;
    logic             rst_n;
    logic             debug;
    logic [1:0]       priv;
    logic [5:0]       cnt_inc;
    logic [5:0][63:0] cnt_val;
    logic [5:0]       cnt_we;
    logic [11:0]      addr;
    logic             we;
    logic [63:0]      wdata;
    logic             lcofi_clr;

    logic [63:0]      rdata64;
    logic [5:0]       inc_en64;
    logic [5:0]       of64;
    logic             lcofi64;
    logic [31:0]      rdata32;
    logic [5:0]       inc_en32;
    logic [5:0]       of32;
    logic             lcofi32;

    int checks;
    int failures;

    hpm_overflow_ctrl #(.CVA6Cfg(Cfg64), .NumCounters(6)) u_dut64 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .debug_mode_i(debug),
        .priv_lvl_i  (priv),
        .cnt_inc_i   (cnt_inc),
        .cnt_val_i   (cnt_val),
        .cnt_we_i    (cnt_we),
        .addr_i      (addr),
        .we_i        (we),
        .data_i      (wdata),
        .data_o      (rdata64),
        .lcofi_clr_i (lcofi_clr),
        .inc_en_o    (inc_en64),
        .of_o        (of64),
        .lcofi_o     (lcofi64)
    );

    hpm_overflow_ctrl #(.CVA6Cfg(Cfg32), .NumCounters(6)) u_dut32 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .debug_mode_i(debug),
        .priv_lvl_i  (priv),
        .cnt_inc_i   (cnt_inc),
        .cnt_val_i   (cnt_val),
        .cnt_we_i    (cnt_we),
        .addr_i      (addr),
        .we_i        (we),
        .data_i      (wdata[31:0]),
        .data_o      (rdata32),
        .lcofi_clr_i (lcofi_clr),
        .inc_en_o    (inc_en32),
        .of_o        (of32),
        .lcofi_o     (lcofi32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cnt_inc   = '0;
        cnt_we    = '0;
        cnt_val   = '0;
        we        = 1'b0;
        lcofi_clr = 1'b0;
        debug     = 1'b0;
    endtask

    task automatic ovf(input int idx);
        cnt_val[idx] = '1;
        cnt_inc[idx] = 1'b1;
    endtask

    task automatic csr_wr(input logic [11:0] a, input logic [63:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        step();
        we = 1'b0;
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        priv     = 2'b11;
        addr     = 12'h323;
        wdata    = '0;
        idle();
        #1;
        check("rst_of", 64'(of64), 64'h0);
        check("rst_lcofi", 64'(lcofi64), 64'h0);
        check("rst_inc_en", 64'(inc_en64), 64'h3F);
        check("rst_cfg_rd", rdata64, 64'h0);
        #20 rst_n = 1'b1;
        step();

        // Overflow on counter 3: one-cycle latency, then scountovf view.
        ovf(0);
        #1;
        check("ovf_pre_edge", 64'(of64), 64'h0);
        step();
        idle();
        #1;
        check("ovf3_of", 64'(of64), 64'h01);
        check("ovf3_lcofi", 64'(lcofi64), 64'h1);
        addr = 12'hDA0;
        #1;
        check("scountovf_8", rdata64, 64'h8);

        // Clearing OF leaves LCOFI pending; only lcofi_clr drops it.
        csr_wr(12'h323, 64'h0);
        check("of_sw_clr", 64'(of64), 64'h0);
        check("lcofi_kept", 64'(lcofi64), 64'h1);
        lcofi_clr = 1'b1;
        step();
        lcofi_clr = 1'b0;
        #1;
        check("lcofi_clr", 64'(lcofi64), 64'h0);
        ovf(0);
        step();
        idle();
        #1;
        check("reraise_fresh", 64'(lcofi64), 64'h1);
        lcofi_clr = 1'b1;
        step();
        lcofi_clr = 1'b0;
        ovf(0);
        step();
        idle();
        #1;
        check("no_reraise_sticky", 64'(lcofi64), 64'h0);
        check("of_sticky", 64'(of64), 64'h01);

        // Software setting OF does not raise the interrupt.
        csr_wr(12'h324, 64'h8000_0000_0000_0000);
        check("sw_of_set", 64'(of64), 64'h03);
        check("sw_of_no_lcofi", 64'(lcofi64), 64'h0);
        addr = 12'h324;
        #1;
        check("cfg4_rd", rdata64, 64'h8000_0000_0000_0000);

        // Privilege inhibit filtering.
        csr_wr(12'h323, 64'h4000_0000_0000_0000);
        check("minh_clr_of", 64'(of64), 64'h02);
        priv = 2'b11;
        #1;
        check("minh_privM", 64'(inc_en64), 64'h3E);
        priv = 2'b01;
        #1;
        check("minh_privS", 64'(inc_en64), 64'h3F);
        addr = 12'h323;
        #1;
        check("minh_rd", rdata64, 64'h4000_0000_0000_0000);
        csr_wr(12'h325, 64'h2000_0000_0000_0000);
        priv = 2'b01;
        #1;
        check("sinh_privS", 64'(inc_en64), 64'h3B);
        priv = 2'b00;
        #1;
        check("sinh_privU", 64'(inc_en64), 64'h3F);
        csr_wr(12'h326, 64'h1000_0000_0000_0000);
        check("uinh_privU", 64'(inc_en64), 64'h37);
        debug = 1'b1;
        #1;
        check("debug_inc_en", 64'(inc_en64), 64'h0);
        priv = 2'b11;
        ovf(2);
        step();
        idle();
        #1;
        check("debug_no_ovf", 64'(of64), 64'h02);

        // Asynchronous reset with an overflow pending discards it.
        ovf(2);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_of", 64'(of64), 64'h0);
        check("async_rst_inc_en", 64'(inc_en64), 64'h3F);
        step();
        idle();
        #2 rst_n = 1'b1;
        step();
        check("rst_discard", 64'(of64), 64'h0);

        // Software write to the counter masks the overflow.
        ovf(2);
        cnt_we[2] = 1'b1;
        step();
        idle();
        #1;
        check("cnt_we_of", 64'(of64), 64'h0);
        check("cnt_we_lcofi", 64'(lcofi64), 64'h0);

        // Overflow and CSR write on the same counter in one cycle.
        csr_wr(12'h324, 64'h7000_0000_0000_0000);
        addr = 12'h324;
        #1;
        check("cfg4_pre", rdata64, 64'h7000_0000_0000_0000);
        wdata = 64'h0;
        we    = 1'b1;
        ovf(1);
        step();
        idle();
        #1;
        check("hw_wins_of", 64'(of64), 64'h02);
        check("hw_wins_rd", rdata64, 64'h8000_0000_0000_0000);
        check("hw_wins_lcofi", 64'(lcofi64), 64'h1);

        // Set beats clear on LCOFI.
        ovf(3);
        lcofi_clr = 1'b1;
        step();
        idle();
        #1;
        check("set_wins_lcofi", 64'(lcofi64), 64'h1);
        check("set_wins_of", 64'(of64), 64'h0A);
        lcofi_clr = 1'b1;
        step();
        lcofi_clr = 1'b0;
        #1;
        check("clr_only", 64'(lcofi64), 64'h0);

        // Several overflows in one edge.
        ovf(4);
        ovf(5);
        step();
        idle();
        #1;
        check("multi_of", 64'(of64), 64'h3A);
        check("multi_lcofi", 64'(lcofi64), 64'h1);
        addr = 12'hDA0;
        #1;
        check("multi_scountovf", rdata64, 64'h1D0);

        // Unmapped addresses.
        addr = 12'h330;
        #1;
        check("unmapped_rd", rdata64, 64'h0);
        addr = 12'h723;
        #1;
        check("rv64_723_rd", rdata64, 64'h0);
        csr_wr(12'h330, '1);
        check("unmapped_wr", 64'(of64), 64'h3A);
        csr_wr(12'hDA0, 64'h0);
        check("scountovf_wr", 64'(of64), 64'h3A);

        // RV32 build.
        rst_n = 1'b0;
        #3 rst_n = 1'b1;
        step();
        csr_wr(12'h723, 64'h0000_0000_8000_0000);
        check("rv32_of", 64'(of32), 64'h01);
        check("rv32_lcofi", 64'(lcofi32), 64'h0);
        addr = 12'h323;
        #1;
        check("rv32_323_rd", 64'(rdata32), 64'h0);
        addr = 12'h723;
        #1;
        check("rv32_723_rd", 64'(rdata32), 64'h8000_0000);
        csr_wr(12'h323, 64'h0000_0000_FFFF_FFFF);
        addr = 12'h723;
        #1;
        check("rv32_323_wr_ignored", 64'(rdata32), 64'h8000_0000);
        check("rv32_inc_en", 64'(inc_en32), 64'h3F);
        ovf(1);
        step();
        idle();
        #1;
        check("rv32_ovf_of", 64'(of32), 64'h03);
        check("rv32_ovf_lcofi", 64'(lcofi32), 64'h1);
        addr = 12'hDA0;
        #1;
        check("rv32_scountovf", 64'(rdata32), 64'h18);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hpm_overflow_ctrl.md
HPM_OVERFLOW_CTRL -- requirements
Module: hpm_overflow_ctrl

Interface
REQ-001 Parameter CVA6Cfg, config_pkg::cva6_cfg_empty, core configuration; XLEN taken from CVA6Cfg.XLEN (32 or 64).
REQ-002 Parameter NumCounters, 6, number of generic HPM counters (mhpmcounter3..).
REQ-003 clk_i  input  1  core clock; the only clock.
REQ-004 rst_ni  input  1  reset; asynchronous assert, active-low.
REQ-005 debug_mode_i  input  1  core in debug mode.
REQ-006 priv_lvl_i  input  2  current privilege (riscv priv_lvl_t: U=0, S=1, M=3).
REQ-007 cnt_inc_i  input  NumCounters  counter i+3 increments this cycle.
REQ-008 cnt_val_i  input  NumCounters x 64  current registered counter values.
REQ-009 cnt_we_i  input  NumCounters  software write to counter i+3 this cycle.
REQ-010 addr_i  input  12  CSR address.
REQ-011 we_i  input  1  CSR write enable.
REQ-012 data_i  input  XLEN  CSR write data.
REQ-013 data_o  output  XLEN  CSR read data, combinational from addr_i.
REQ-014 lcofi_clr_i  input  1  software clears the LCOFI pending bit (mip.LCOFIP write 0).
REQ-015 inc_en_o  output  NumCounters  privilege-filtered increment enable to the counter block.
REQ-016 of_o  output  NumCounters  sticky overflow flags.
REQ-017 lcofi_o  output  1  local counter-overflow interrupt pending.

Function
REQ-018 Per counter i: 4-bit config register {OF, MINH, SINH, UINH}.
REQ-019 inc_en_o[i] SHALL be 0 when (MINH and priv M) or (SINH and priv S) or (UINH and priv U) or debug_mode_i, else 1; purely combinational.
REQ-020 Overflow event i: cnt_inc_i[i]=1, cnt_val_i[i]=64'hFFFF_FFFF_FFFF_FFFF, cnt_we_i[i]=0, debug_mode_i=0.
REQ-021 Overflow event SHALL set OF[i] on the next rising edge (1-cycle latency); of_o reflects the register.
REQ-022 CSR map, XLEN=64: 0x323+i returns config at bits [63:60] = {OF,MINH,SINH,UINH}, other bits 0; writes update all four bits.
REQ-023 CSR map, XLEN=32: 0x723+i (mhpmeventh) returns config at bits [31:28]; 0x323+i reads 0 and ignores writes.
REQ-024 0xDA0 (scountovf) read returns OF[i] at bit i+3, all other bits 0; writes ignored.
REQ-025 Addresses outside the mapped ranges SHALL read 0 and ignore writes.
REQ-026 Simultaneous overflow event and CSR write to the same OF bit: hardware set wins (OF=1); MINH/SINH/UINH take the written value.
REQ-027 lcofi_o SHALL set on the edge after any OF bit transitions 0->1 due to an overflow event; software writing OF 0->1 SHALL NOT set lcofi_o.
REQ-028 lcofi_o SHALL remain set until lcofi_clr_i; simultaneous set and clear: set wins.
REQ-029 Clearing OF bits SHALL NOT clear lcofi_o; an overflow on an already-set OF[i] SHALL NOT re-raise lcofi_o.
REQ-030 Overflow events on multiple counters in one cycle SHALL set all corresponding OF bits in that edge.

Reset
REQ-031 On rst_ni=0, all config registers and lcofi_o SHALL clear to 0 immediately; inc_en_o then reads all 1 outside debug mode.
REQ-032 Reset asserted mid-cycle with a pending overflow event SHALL discard the event.

Verification
REQ-033 XLEN=64, counter 3 = all-ones, cnt_inc_i[0]=1 -> of_o[0]=1 and lcofi_o=1 one cycle later; scountovf reads 0x8.
REQ-034 Write 0x323 data 1<<62 (MINH), priv M -> inc_en_o[0]=0; priv S -> inc_en_o[0]=1.
REQ-035 Overflow on counter 5 with cnt_we_i[2]=1 -> of_o[2] stays 0, lcofi_o stays 0.
REQ-036 Same cycle: overflow counter 4 and write 0x324 data 0 -> of_o[1]=1, MINH/SINH/UINH=0.
REQ-037 lcofi_o=1, overflow on fresh counter 6 with lcofi_clr_i=1 same cycle -> lcofi_o=1; next cycle clear only -> 0.
REQ-038 XLEN=32: write 0x723 data 0x8000_0000 -> of_o[0]=1, lcofi_o stays 0; read 0x323 returns 0.
